// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter slice.
//   state_t : arbiter FSM state encoding (IDLE / GRANT / WRITE)
//   idx_w() : width of a requester index for a given requester count
package shared_reg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // IDXW helper: $clog2 of the requester count, never narrower than 1 bit
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : per-requester request vector
//   ptr    : index where the priority search starts
//   any    : at least one request is present
//   winner : first requester with req set, searching ascending from ptr
//            and wrapping from NREQ-1 back to 0
module rr_pick
   import shared_reg_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDXW = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic            any,
   output logic [IDXW-1:0] winner
);

   int unsigned w_idx;

   always_comb begin
      any    = 1'b0;
      winner = '0;
      w_idx  = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         // explicit wrap keeps the rotation correct for non-power-of-2 NREQ
         w_idx = 32'(ptr) + i;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!any && req[IDXW'(w_idx)]) begin
            any    = 1'b1;
            winner = IDXW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin controller for one shared WIDTH-bit register written by NREQ
// requesters. One requester is granted at a time; the granted requester's
// data is loaded into the shared register and the write is acknowledged.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   req   : per-requester write request (level, held until ack)
//   wdata : write data, requester i on bits [i*WIDTH +: WIDTH]
//   gnt   : one-hot registered grant, high during GRANT
//   ack   : one-hot one-cycle write-done pulse, high during WRITE
//   q     : shared register contents
//   owner : index of the last requester that completed a write
//   busy  : high in GRANT and WRITE
module shared_reg_arbiter
   import shared_reg_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WIDTH-1:0]    wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          ack,
   output logic [WIDTH-1:0]         q,
   output logic [idx_w(NREQ)-1:0]   owner,
   output logic                     busy
);

   localparam int IDXW = idx_w(NREQ);
   localparam logic [IDXW-1:0] LAST = IDXW'(NREQ - 1);

   state_t           r_state, w_state_nxt;
   logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
   logic [NREQ-1:0]  r_ack, w_ack_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt;
   logic [IDXW-1:0]  r_owner, w_owner_nxt;
   logic [IDXW-1:0]  r_ptr, w_ptr_nxt;
   logic [IDXW-1:0]  r_win, w_win_nxt;
   logic             r_busy, w_busy_nxt;

   logic             w_any;
   logic [IDXW-1:0]  w_winner;
   logic [WIDTH-1:0] w_lane [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign w_lane[gi] = wdata[gi*WIDTH +: WIDTH];
   end

   rr_pick #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .any    (w_any),
      .winner (w_winner)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_q     <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_win   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ack   <= w_ack_nxt;
         r_q     <= w_q_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_win   <= w_win_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_any) w_state_nxt = ST_GRANT;
         ST_GRANT: w_state_nxt = req[r_win] ? ST_WRITE : ST_IDLE;
         ST_WRITE: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; all outputs come straight from
   // registers so grant/ack never glitch with req.
   always_comb begin
      w_gnt_nxt   = '0;
      w_ack_nxt   = '0;
      w_q_nxt     = r_q;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_win_nxt   = r_win;
      w_busy_nxt  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_gnt_nxt[w_winner] = 1'b1;
               w_win_nxt           = w_winner;
               w_busy_nxt          = 1'b1;
            end
         end
         ST_GRANT: begin
            // a dropped request aborts: no write, pointer keeps its priority
            if (req[r_win]) begin
               w_q_nxt          = w_lane[r_win];
               w_ack_nxt[r_win] = 1'b1;
               w_owner_nxt      = r_win;
               w_ptr_nxt        = (r_win == LAST) ? '0 : r_win + 1'b1;
               w_busy_nxt       = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign gnt   = r_gnt;
   assign ack   = r_ack;
   assign q     = r_q;
   assign owner = r_owner;
   assign busy  = r_busy;

endmodule
